// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// One bit per cycle; holds the pipeline on ex_stall_o until the result is ready.
//
// state  | meaning
// IDLE   | waiting for an M-op in EX; start edge latches operands
// BUSY   | iterating, count 0..31, one bit per edge
// DONE   | result_o valid, done_o pulses, pipeline released
module muldiv_seq #(
   parameter int WIDTH        = 32,
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] port_a,
   input  logic [WIDTH-1:0] port_b,
   input  logic             flush_i,
   output logic             ex_stall_o,
   output logic             done_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [2:0]         op_q;
   logic               sign_x;     // operand signs differ: product / quotient negative
   logic               sign_a;     // dividend negative: remainder negative
   logic [4:0]         count;
   logic [WIDTH-1:0]   opnd;       // multiplicand for mul, divisor for div
   logic [2*WIDTH-1:0] acc;        // mul: {hi, multiplier/lo}; div: {remainder, quotient}

   logic               start_ok;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic               special;
   logic [WIDTH-1:0]   special_res;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] acc_nxt;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   res_nxt;

   assign start_ok   = (state == S_IDLE) & start_i & ~flush_i;
   // Gated by reset so the stall is also low while rst holds the unit idle.
   assign ex_stall_o = rst & (start_ok | (state == S_BUSY));
   assign done_o     = (state == S_DONE) & ~flush_i;
   assign busy_o     = (state == S_BUSY);

   // Operand conditioning and the single-cycle special cases at the start edge.
   always_comb begin
      a_neg       = 1'b0;
      b_neg       = 1'b0;
      special     = 1'b0;
      special_res = '0;
      // MULH, MULHSU, DIV, REM treat a as signed; MULH, DIV, REM treat b as signed.
      if (op_i == 3'd1 || op_i == 3'd2 || op_i == 3'd4 || op_i == 3'd6)
         a_neg = port_a[WIDTH-1];
      if (op_i == 3'd1 || op_i == 3'd4 || op_i == 3'd6)
         b_neg = port_b[WIDTH-1];
      a_abs = a_neg ? (~port_a + 1'b1) : port_a;
      b_abs = b_neg ? (~port_b + 1'b1) : port_b;
      if (FAST_SPECIAL && op_i[2]) begin
         if (port_b == '0) begin
            special     = 1'b1;
            special_res = op_i[1] ? port_a : '1;
         end else if (!op_i[0] && port_a == {1'b1, {(WIDTH-1){1'b0}}} && port_b == '1) begin
            special     = 1'b1;
            special_res = op_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
         end
      end
   end

   // One shift-add or restoring-divide step, plus the sign-corrected final result.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd};
      acc_nxt   = acc;
      if (!op_q[2])
         acc_nxt = {mul_sum, acc[WIDTH-1:1]};
      else if (div_diff[WIDTH])
         acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      prod_fix = sign_x ? (~acc_nxt + 1'b1) : acc_nxt;
      quo_fix  = sign_x ? (~acc_nxt[WIDTH-1:0] + 1'b1) : acc_nxt[WIDTH-1:0];
      rem_fix  = sign_a ? (~acc_nxt[2*WIDTH-1:WIDTH] + 1'b1) : acc_nxt[2*WIDTH-1:WIDTH];
      case (op_q)
         3'd0:       res_nxt = prod_fix[WIDTH-1:0];
         3'd4, 3'd5: res_nxt = quo_fix;
         3'd6, 3'd7: res_nxt = rem_fix;
         default:    res_nxt = prod_fix[2*WIDTH-1:WIDTH];
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start_ok) state_nxt = special ? S_DONE : S_BUSY;
         S_BUSY: begin
            if (flush_i)             state_nxt = S_IDLE;
            else if (count == 5'd31) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Operand latch, iteration registers and result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q     <= '0;
         sign_x   <= 1'b0;
         sign_a   <= 1'b0;
         count    <= '0;
         opnd     <= '0;
         acc      <= '0;
         result_o <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  op_q   <= op_i;
                  sign_x <= a_neg ^ b_neg;
                  sign_a <= a_neg;
                  count  <= '0;
                  opnd   <= op_i[2] ? b_abs : a_abs;
                  acc    <= {{WIDTH{1'b0}}, (op_i[2] ? a_abs : b_abs)};
                  if (special) result_o <= special_res;
               end
            end
            S_BUSY: begin
               if (!flush_i) begin
                  acc   <= acc_nxt;
                  count <= count + 5'd1;
                  if (count == 5'd31) result_o <= res_nxt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of expected results per op.
module tb_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] port_a;
   logic [31:0] port_b;
   logic        flush_i;
   logic        ex_stall_o;
   logic        done_o;
   logic        busy_o;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_res;

   muldiv_seq #(.WIDTH(32), .FAST_SPECIAL(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .port_a     (port_a),
      .port_b     (port_b),
      .flush_i    (flush_i),
      .ex_stall_o (ex_stall_o),
      .done_o     (done_o),
      .busy_o     (busy_o),
      .result_o   (result_o)
   );

   always #5 clk = ~clk;

   // Drive one op from an IDLE cycle and watch until done_o (bounded).
   // Operands are scrambled after the start edge; the DUT must ignore them.
   // Leaves start_i high through the DONE cycle, as a stalled pipeline would.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls, output int busys,
                        output logic [31:0] res);
      @(negedge clk);
      start_i = 1'b1;
      op_i    = op;
      port_a  = a;
      port_b  = b;
      lat = -1; stalls = 0; busys = 0; res = 32'hDEAD_BEEF;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (done_o === 1'b1) begin
            lat = c;
            res = result_o;
            break;
         end
         if (ex_stall_o === 1'b1) stalls++;
         if (busy_o === 1'b1) busys++;
         @(negedge clk);
         op_i   = 3'($urandom_range(0, 7));
         port_a = $urandom;
         port_b = $urandom;
      end
   endtask

   task automatic drop_start();
      @(negedge clk);
      start_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start_i = 1'b0; flush_i = 1'b0;
      op_i = '0; port_a = '0; port_b = '0;
      #1;
      total++; if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=%h", result_o, 32'h0); end
      total++; if (done_o !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
      total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", ex_stall_o); end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      int lat, st, bz; logic [31:0] res, exp;
      sb_q.push_back(32'h0000_002A);
      do_op(3'd0, 32'd7, 32'd6, lat, st, bz, res);
      total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL mul_stall_in_done got=%b want=0", ex_stall_o); end
      exp = sb_q.pop_front(); last_res = exp;
      total++; if (res !== exp)  begin bad++; $display("FAIL mul_result got=%h want=%h", res, exp); end
      total++; if (lat !== 33)   begin bad++; $display("FAIL mul_latency got=%0d want=33", lat); end
      total++; if (st !== 33)    begin bad++; $display("FAIL mul_stall_cycles got=%0d want=33", st); end
      total++; if (bz !== 32)    begin bad++; $display("FAIL mul_busy_cycles got=%0d want=32", bz); end
      drop_start();
      sb_q.push_back(32'hFFFF_FFFE);
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, st, bz, res);
      exp = sb_q.pop_front(); last_res = exp;
      total++; if (res !== exp)  begin bad++; $display("FAIL mulhu_result got=%h want=%h", res, exp); end
      total++; if (lat !== 33)   begin bad++; $display("FAIL mulhu_latency got=%0d want=33", lat); end
      drop_start();
   endtask

   task automatic test_div();
      logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [31:0] ex  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
      int lat, st, bz; logic [31:0] res, exp;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(ex[i]);
         do_op(ops[i], as[i], bs[i], lat, st, bz, res);
         exp = sb_q.pop_front(); last_res = exp;
         total++; if (res !== exp) begin bad++; $display("FAIL div_result[%0d] got=%h want=%h", i, res, exp); end
         total++; if (lat !== 33)  begin bad++; $display("FAIL div_latency[%0d] got=%0d want=33", i, lat); end
         drop_start();
      end
   endtask

   task automatic test_special();
      logic [2:0]  ops [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
      logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int lat, st, bz; logic [31:0] res, exp;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(ex[i]);
         do_op(ops[i], as[i], bs[i], lat, st, bz, res);
         exp = sb_q.pop_front(); last_res = exp;
         total++; if (res !== exp) begin bad++; $display("FAIL special_result[%0d] got=%h want=%h", i, res, exp); end
         total++; if (lat !== 1)   begin bad++; $display("FAIL special_latency[%0d] got=%0d want=1", i, lat); end
         total++; if (st !== 1)    begin bad++; $display("FAIL special_stalls[%0d] got=%0d want=1", i, st); end
         drop_start();
      end
   endtask

   task automatic test_mulh();
      int lat, st, bz; logic [31:0] res, exp;
      sb_q.push_back(32'h4000_0000);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, lat, st, bz, res);
      exp = sb_q.pop_front(); last_res = exp;
      total++; if (res !== exp) begin bad++; $display("FAIL mulh_result got=%h want=%h", res, exp); end
      drop_start();
      sb_q.push_back(32'hFFFF_FFFF);
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2, lat, st, bz, res);
      exp = sb_q.pop_front(); last_res = exp;
      total++; if (res !== exp) begin bad++; $display("FAIL mulhsu_result got=%h want=%h", res, exp); end
      drop_start();
   endtask

   task automatic test_flush();
      int dones = 0, stalls = 0;
      @(negedge clk);
      start_i = 1'b1; op_i = 3'd4; port_a = 32'd100; port_b = 32'd7;
      repeat (10) @(negedge clk);
      flush_i = 1'b1;
      #1;
      total++; if (ex_stall_o !== 1'b1) begin bad++; $display("FAIL flush_busy_stall got=%b want=1", ex_stall_o); end
      @(negedge clk);
      flush_i = 1'b0; start_i = 1'b0;
      #1;
      total++; if (busy_o !== 1'b0)       begin bad++; $display("FAIL flush_busy got=%b want=0", busy_o); end
      total++; if (result_o !== last_res) begin bad++; $display("FAIL flush_result got=%h want=%h", result_o, last_res); end
      for (int c = 0; c < 40; c++) begin
         if (done_o === 1'b1) dones++;
         if (ex_stall_o === 1'b1) stalls++;
         @(negedge clk); #1;
      end
      total++; if (dones !== 0)  begin bad++; $display("FAIL flush_done_pulses got=%0d want=0", dones); end
      total++; if (stalls !== 0) begin bad++; $display("FAIL flush_stalls got=%0d want=0", stalls); end
      @(negedge clk);
      start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; port_a = 32'd3; port_b = 32'd3;
      #1;
      total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b want=0", ex_stall_o); end
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      #1;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b want=0", busy_o); end
   endtask

   task automatic test_reset_mid();
      int lat, st, bz; logic [31:0] res, exp;
      @(negedge clk);
      start_i = 1'b1; op_i = 3'd0; port_a = 32'd7; port_b = 32'd6;
      repeat (15) @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (result_o !== 32'h0)  begin bad++; $display("FAIL midrst_result got=%h want=0", result_o); end
      total++; if (busy_o !== 1'b0)     begin bad++; $display("FAIL midrst_busy got=%b want=0", busy_o); end
      total++; if (ex_stall_o !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b want=0", ex_stall_o); end
      total++; if (done_o !== 1'b0)     begin bad++; $display("FAIL midrst_done got=%b want=0", done_o); end
      @(negedge clk);
      start_i = 1'b0;
      rst = 1'b1;
      sb_q.push_back(32'd3);
      do_op(3'd5, 32'd9, 32'd3, lat, st, bz, res);
      exp = sb_q.pop_front(); last_res = exp;
      total++; if (res !== exp) begin bad++; $display("FAIL midrst_divu_result got=%h want=%h", res, exp); end
      total++; if (lat !== 33)  begin bad++; $display("FAIL midrst_divu_latency got=%0d want=33", lat); end
      drop_start();
   endtask

   task automatic test_back_to_back();
      int lat, st, bz, dones = 0; logic [31:0] res, exp;
      sb_q.push_back(32'd45);
      do_op(3'd0, 32'd5, 32'd9, lat, st, bz, res);
      exp = sb_q.pop_front(); last_res = exp;
      total++; if (res !== exp) begin bad++; $display("FAIL b2b_mul_result got=%h want=%h", res, exp); end
      total++; if (lat !== 33)  begin bad++; $display("FAIL b2b_mul_latency got=%0d want=33", lat); end
      sb_q.push_back(32'hFFFF_FFF2);
      do_op(3'd4, 32'd100, 32'hFFFF_FFF9, lat, st, bz, res);
      exp = sb_q.pop_front(); last_res = exp;
      total++; if (res !== exp) begin bad++; $display("FAIL b2b_div_result got=%h want=%h", res, exp); end
      total++; if (lat !== 33)  begin bad++; $display("FAIL b2b_div_latency got=%0d want=33", lat); end
      drop_start();
      total++; if (busy_o !== 1'b0 || ex_stall_o !== 1'b0) begin
         bad++; $display("FAIL b2b_no_restart busy=%b stall=%b want=0,0", busy_o, ex_stall_o);
      end
      for (int c = 0; c < 5; c++) begin
         if (done_o === 1'b1) dones++;
         @(negedge clk); #1;
      end
      total++; if (dones !== 0) begin bad++; $display("FAIL b2b_extra_done got=%0d want=0", dones); end
      total++; if (result_o !== last_res) begin bad++; $display("FAIL b2b_result_hold got=%h want=%h", result_o, last_res); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_mulh();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
